// File: rtl/rsfq_xor_pulse_driver_pkg.sv
// Shared state encoding, parameter floors and small helpers for the RSFQ XOR pulse driver.
package rsfq_drv_pkg;

  typedef enum logic [3:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_PA,
    ST_PB,
    ST_SETUP,
    ST_CLKP,
    ST_WAIT,
    ST_REPORT,
    ST_RECOVER
  } drv_state_t;

  localparam int SETUP_GAP_MIN    = 1;
  localparam int RESP_TIMEOUT_MIN = 3;
  localparam int RECOVER_GAP_MIN  = 1;
  localparam int CNT_W_MIN        = 1;

  function automatic int max3(input int x, input int y, input int z);
    int m;
    m = (x > y) ? x : y;
    return (m > z) ? m : z;
  endfunction

  // Two-bit seen counter: sticks at 3 so "more than one toggle" stays distinguishable.
  function automatic logic [1:0] sat_inc2(input logic [1:0] v, input logic en);
    return (en && v != 2'd3) ? v + 2'd1 : v;
  endfunction

endpackage

// File: rtl/rsfq_xor_pulse_driver_toggle_sync.sv
// Brings an asynchronous toggle-encoded line into clk and emits a one-cycle pulse per level change.
// Latency 2-3 cycles from the line edge; no backpressure.
module rsfq_toggle_sync (
  input  logic clk,
  input  logic rst,
  input  logic tgl,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic sync3;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= tgl;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign pulse = sync2 ^ sync3;

endmodule

// File: rtl/rsfq_xor_pulse_driver.sv
// Drives toggle-encoded a/b/clk pulses into a clocked RSFQ XOR cell and grades its q response.
// Latency accept->res_valid = 3 + SETUP_GAP + RESP_TIMEOUT; one request in flight, in_ready low until recovery ends.
module rsfq_xor_pulse_driver
  import rsfq_drv_pkg::*;
#(
  parameter int SETUP_GAP    = 2,
  parameter int RESP_TIMEOUT = 8,
  parameter int RECOVER_GAP  = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_a,
  input  logic             in_b,
  output logic             sfq_a,
  output logic             sfq_b,
  output logic             sfq_clk,
  input  logic             sfq_q,
  output logic             res_valid,
  output logic             res_bit,
  output logic             res_err,
  output logic             spurious,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] err_count
);

  if (SETUP_GAP < SETUP_GAP_MIN) begin : g_bad_setup
    $error("SETUP_GAP below minimum");
  end
  if (RESP_TIMEOUT < RESP_TIMEOUT_MIN) begin : g_bad_timeout
    $error("RESP_TIMEOUT below minimum");
  end
  if (RECOVER_GAP < RECOVER_GAP_MIN) begin : g_bad_recover
    $error("RECOVER_GAP below minimum");
  end
  if (CNT_W < CNT_W_MIN) begin : g_bad_cnt
    $error("CNT_W below minimum");
  end

  localparam int TMR_MAX = max3(SETUP_GAP, RESP_TIMEOUT, RECOVER_GAP);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] SETUP_END   = TMR_W'(SETUP_GAP);
  localparam logic [TMR_W-1:0] WINDOW_END  = TMR_W'(RESP_TIMEOUT);
  localparam logic [TMR_W-1:0] RECOVER_END = TMR_W'(RECOVER_GAP);

  drv_state_t       state;
  logic [TMR_W-1:0] tmr;
  logic             b_r;
  logic             exp_r;
  logic [1:0]       seen;
  logic [1:0]       seen_nxt;
  logic             q_det;
  logic             spur_evt;
  logic             pass_inc;
  logic             err_inc;

  rsfq_toggle_sync u_q_sync (
    .clk   (clk),
    .rst   (rst),
    .tgl   (sfq_q),
    .pulse (q_det)
  );

  assign in_ready = (state == ST_IDLE);

  // FLUSH discards detections; CLKP and WAIT count them as the cell's answer.
  always_comb begin
    seen_nxt = sat_inc2(seen, q_det);
    spur_evt = q_det && (state inside {ST_IDLE, ST_PA, ST_PB, ST_SETUP, ST_REPORT, ST_RECOVER});
    pass_inc = (state == ST_REPORT) && !res_err;
    // A report owns the error counter for its cycle; a coincident spurious toggle only sets the flag.
    err_inc  = (state == ST_REPORT) ? res_err : spur_evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_FLUSH;
      tmr        <= '0;
      b_r        <= 1'b0;
      exp_r      <= 1'b0;
      seen       <= 2'd0;
      sfq_a      <= 1'b0;
      sfq_b      <= 1'b0;
      sfq_clk    <= 1'b0;
      res_valid  <= 1'b0;
      res_bit    <= 1'b0;
      res_err    <= 1'b0;
      spurious   <= 1'b0;
      pass_count <= '0;
      err_count  <= '0;
    end else begin
      res_valid <= 1'b0;
      if (spur_evt) spurious <= 1'b1;
      if (pass_inc && pass_count != '1) pass_count <= pass_count + 1'b1;
      if (err_inc && err_count != '1) err_count <= err_count + 1'b1;

      case (state)
        ST_FLUSH: begin
          if (tmr == '0) begin
            sfq_clk <= ~sfq_clk;
            tmr     <= TMR_W'(1);
          end else if (tmr == WINDOW_END) begin
            tmr   <= '0;
            state <= ST_IDLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_IDLE: begin
          if (in_valid) begin
            b_r   <= in_b;
            exp_r <= in_a ^ in_b;
            sfq_a <= sfq_a ^ in_a;
            state <= ST_PA;
          end
        end
        ST_PA: begin
          sfq_b <= sfq_b ^ b_r;
          state <= ST_PB;
        end
        ST_PB: begin
          tmr   <= TMR_W'(1);
          state <= ST_SETUP;
        end
        ST_SETUP: begin
          if (tmr == SETUP_END) begin
            sfq_clk <= ~sfq_clk;
            seen    <= 2'd0;
            state   <= ST_CLKP;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_CLKP: begin
          seen  <= seen_nxt;
          tmr   <= TMR_W'(1);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          seen <= seen_nxt;
          if (tmr == WINDOW_END) begin
            res_valid <= 1'b1;
            res_bit   <= (seen_nxt != 2'd0);
            res_err   <= exp_r ? (seen_nxt != 2'd1) : (seen_nxt != 2'd0);
            state     <= ST_REPORT;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_REPORT: begin
          tmr   <= TMR_W'(1);
          state <= ST_RECOVER;
        end
        ST_RECOVER: begin
          if (tmr == RECOVER_END) begin
            tmr   <= '0;
            state <= ST_IDLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: begin
          tmr   <= '0;
          state <= ST_FLUSH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsfq_xor_pulse_driver.sv
// Drives the pulse driver against a behavioural XOR-cell environment and checks results, timing and counters.
module tb_rsfq_xor_pulse_driver;

  localparam int SG  = 2;
  localparam int RT  = 8;
  localparam int RG  = 2;
  localparam int LAT = 2 + SG + 1 + RT;

  localparam int M_CELL   = 0;
  localparam int M_NONE   = 1;
  localparam int M_DOUBLE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_a = 1'b0;
  logic        in_b = 1'b0;
  logic        q_line = 1'b0;
  logic        in_ready, sfq_a, sfq_b, sfq_clk, res_valid, res_bit, res_err, spurious;
  logic [15:0] pass_count, err_count;
  logic        in_ready2, sfq_a2, sfq_b2, sfq_clk2, res_valid2, res_bit2, res_err2, spurious2;
  logic [1:0]  pass_count2, err_count2;

  int n_checks = 0;
  int n_errors = 0;
  int ref_pass = 0;
  int ref_err  = 0;
  logic exp_spur = 1'b0;

  rsfq_xor_pulse_driver #(.SETUP_GAP(SG), .RESP_TIMEOUT(RT), .RECOVER_GAP(RG), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .sfq_a(sfq_a), .sfq_b(sfq_b), .sfq_clk(sfq_clk), .sfq_q(q_line),
    .res_valid(res_valid), .res_bit(res_bit), .res_err(res_err), .spurious(spurious),
    .pass_count(pass_count), .err_count(err_count)
  );

  // Narrow-counter copy sees identical stimulus and q, so its counts are the saturated ones.
  rsfq_xor_pulse_driver #(.SETUP_GAP(SG), .RESP_TIMEOUT(RT), .RECOVER_GAP(RG), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_a(in_a), .in_b(in_b),
    .sfq_a(sfq_a2), .sfq_b(sfq_b2), .sfq_clk(sfq_clk2), .sfq_q(q_line),
    .res_valid(res_valid2), .res_bit(res_bit2), .res_err(res_err2), .spurious(spurious2),
    .pass_count(pass_count2), .err_count(err_count2)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Cell environment: counts data pulses since the last clk pulse and answers on q.
  int   mode = M_CELL;
  int   man_cnt = 0;
  int   man_seen = 0;
  int   pend = 0;
  int   second = 0;
  logic pa_e = 1'b0, pb_e = 1'b0, pc_e = 1'b0;

  always @(negedge clk) begin : cell_env
    int d;
    int nt;
    d  = int'(sfq_a !== pa_e) + int'(sfq_b !== pb_e);
    nt = 0;
    if (second == 1) nt = nt + 1;
    if (second != 0) second <= second - 1;
    if (sfq_clk !== pc_e) begin
      if (mode == M_CELL && pend + d == 1) nt = nt + 1;
      if (mode == M_DOUBLE) begin
        nt = nt + 1;
        second <= 3;
      end
      pend <= 0;
    end else begin
      pend <= pend + d;
    end
    if (man_cnt != man_seen) begin
      nt = nt + 1;
      man_seen <= man_cnt;
    end
    if (nt % 2 == 1) q_line <= ~q_line;
    pa_e <= sfq_a;
    pb_e <= sfq_b;
    pc_e <= sfq_clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_pass"}, 32'(pass_count), sat(ref_pass, 65535));
    check({tag, "_err"}, 32'(err_count), sat(ref_err, 65535));
    check({tag, "_pass_sat"}, 32'(pass_count2), sat(ref_pass, 3));
    check({tag, "_err_sat"}, 32'(err_count2), sat(ref_err, 3));
    check({tag, "_spur"}, 32'(spurious), 32'(exp_spur));
  endtask

  task automatic do_reset();
    int waited;
    mode = M_CELL;
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    check("rst_lines", {29'd0, sfq_a, sfq_b, sfq_clk}, 0);
    check("rst_ready", 32'(in_ready), 0);
    check("rst_res", {30'd0, res_valid, res_bit | res_err}, 0);
    ref_pass = 0;
    ref_err  = 0;
    exp_spur = 1'b0;
    check_counters("rst");
    rst = 1'b0;
    step();
    check("flush_clk", 32'(sfq_clk), 1);
    waited = 0;
    while (!in_ready && waited < 50) begin
      step();
      waited++;
    end
    check("flush_len", waited, RT);
  endtask

  task automatic run_req(input logic a, input logic b, input int md, input int inj);
    int   waited, i, res_at, t_a, t_b, t_c, n_a, n_b, n_c, n_exp;
    logic pa, pb, pc, got_bit, got_err, exp_err;
    mode = md;
    waited = 0;
    while (!in_ready && waited < 100) begin
      step();
      waited++;
    end
    check("ready_wait", 32'(waited < 100), 1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    pa = sfq_a; pb = sfq_b; pc = sfq_clk;
    t_a = 0; t_b = 0; t_c = 0; n_a = 0; n_b = 0; n_c = 0;
    res_at = 0; got_bit = 1'b0; got_err = 1'b0;
    step();
    in_valid = 1'b0;
    in_a = 1'($urandom);
    in_b = 1'($urandom);
    for (i = 1; i <= 60; i++) begin
      if (sfq_a !== pa) begin n_a++; if (t_a == 0) t_a = i; pa = sfq_a; end
      if (sfq_b !== pb) begin n_b++; if (t_b == 0) t_b = i; pb = sfq_b; end
      if (sfq_clk !== pc) begin n_c++; if (t_c == 0) t_c = i; pc = sfq_clk; end
      if (res_valid) begin
        res_at = i; got_bit = res_bit; got_err = res_err;
        break;
      end
      if (i == inj - 1) man_cnt++;
      step();
    end
    n_exp   = (md == M_CELL) ? int'(a ^ b) : (md == M_DOUBLE) ? 2 : 0;
    exp_err = (a ^ b) ? (n_exp != 1) : (n_exp != 0);
    check("latency", res_at, LAT + 1);
    check("a_cycle", t_a, a ? 1 : 0);
    check("a_count", n_a, 32'(a));
    check("b_cycle", t_b, b ? 2 : 0);
    check("b_count", n_b, 32'(b));
    check("clk_cycle", t_c, SG + 3);
    check("clk_count", n_c, 1);
    check("res_bit", 32'(got_bit), 32'(n_exp != 0));
    check("res_err", 32'(got_err), 32'(exp_err));
    if (exp_err) ref_err++;
    else ref_pass++;
    step();
    check_counters("post_report");
    for (int j = 2; j <= RG; j++) step();
    check("recover_ready_lo", 32'(in_ready), 0);
    step();
    check("recover_ready_hi", 32'(in_ready), 1);
  endtask

  initial begin
    logic [1:0] pair;
    int         r;
    do_reset();

    for (int k = 0; k < 4; k++) begin
      pair = 2'(k);
      run_req(pair[1], pair[0], M_CELL, 0);
    end
    check("four_pairs_pass", 32'(pass_count), 4);
    check("four_pairs_sat", 32'(pass_count2), 3);

    run_req(1'b1, 1'b0, M_NONE, 0);
    run_req(1'b0, 1'b1, M_DOUBLE, 0);
    run_req(1'b0, 1'b0, M_DOUBLE, 0);

    for (int k = 0; k < 24; k++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        in_a = 1'($urandom);
        in_b = 1'($urandom);
        step();
      end
      r = $urandom_range(0, 9);
      run_req(1'($urandom), 1'($urandom), (r < 7) ? M_CELL : (r < 9) ? M_NONE : M_DOUBLE, 0);
    end

    // Stray q toggle while idle.
    mode = M_NONE;
    man_cnt++;
    for (int k = 0; k < 5; k++) step();
    ref_err++;
    exp_spur = 1'b1;
    check_counters("idle_spur");

    // Stray toggle detected in the report cycle of a failing request.
    run_req(1'b1, 1'b0, M_NONE, LAT - 1);

    // Reset in the middle of the response window.
    mode = M_CELL;
    while (!in_ready) step();
    in_valid = 1'b1;
    in_a = 1'b1;
    in_b = 1'b0;
    step();
    in_valid = 1'b0;
    for (int k = 1; k < SG + 6; k++) step();
    do_reset();
    run_req(1'b1, 1'b0, M_CELL, 0);
    run_req(1'b1, 1'b1, M_CELL, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
